// File: rtl/seq_bin2bcd_if.sv
// Handshake and result bus of the sequential binary-to-BCD converter.
// The requester drives start/binary; the converter returns ready/done/bcd/overflow.
interface seq_bin2bcd_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [BIN_W-1:0]      binary;
    logic                  ready;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;

    modport master (output start, binary, input ready, done, bcd, overflow);
    modport slave  (input start, binary, output ready, done, bcd, overflow);
endinterface

// File: rtl/seq_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// The working register always holds enough digits for 2^BIN_W-1, so digits
// beyond DIGITS only feed the saturation (overflow) detect.
// Optional build macro: BIN2BCD_BLANK_LEADING_EN replaces leading zero digits
// above digit 0 with 4'hF (7-seg blank code) in non-saturated results.

// Single-nibble dabble correction: add 3 when the digit is 5 or more.
module seq_bin2bcd_nib (
    input  logic [3:0] d,
    output logic [3:0] q
);
    assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module seq_bin2bcd #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    seq_bin2bcd_if.slave  bus
);
    // floor(BIN_W*log10(2))+1 digits cover 2^BIN_W-1
    localparam int FULL_DIG = (BIN_W * 30103) / 100000 + 1;
    localparam int WD       = (FULL_DIG > DIGITS) ? FULL_DIG : DIGITS;
    localparam int SR_W     = 4 * WD + BIN_W;
    localparam int CW       = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state, nstate;
    logic [SR_W-1:0]         sr, sr_sh;
    logic [CW-1:0]           cnt;
    logic                    last;
    logic [WD-1:0][3:0]      nib, adj, res;
    logic [DIGITS-1:0][3:0]  bcd_nx, bcd_q;
    logic                    ovf_nx, ovf_q, ready_q, done_q;
`ifdef BIN2BCD_BLANK_LEADING_EN
    logic                    lead;
`endif

    assign nib   = sr[SR_W-1:BIN_W];
    seq_bin2bcd_nib u_nib [WD-1:0] (.d(nib), .q(adj));
    assign sr_sh = {adj, sr[BIN_W-1:0]} << 1;
    assign res   = sr_sh[SR_W-1:BIN_W];
    assign last  = (cnt == CW'(BIN_W - 1));

    // Result formatting from the register as it will be after the final shift
    always_comb begin
        ovf_nx = 1'b0;
        for (int k = DIGITS; k < WD; k++)
            ovf_nx = ovf_nx | (res[k] != 4'd0);
        bcd_nx = res[DIGITS-1:0];
`ifdef BIN2BCD_BLANK_LEADING_EN
        lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (lead && (res[k] == 4'd0)) bcd_nx[k] = 4'hF;
            else                          lead      = 1'b0;
        end
`endif
        if (ovf_nx) bcd_nx = {DIGITS{4'h9}};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // Next-state logic
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (bus.start) nstate = SHIFT;
            SHIFT:   if (last)      nstate = DONE;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Datapath and registered outputs; done is the registered image of DONE,
    // so it rises on the edge that returns the FSM to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr      <= '0;
            cnt     <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            ready_q <= (nstate == IDLE);
            done_q  <= (state == DONE);
            case (state)
                IDLE: if (bus.start) begin
                    sr  <= SR_W'(bus.binary);
                    cnt <= '0;
                end
                SHIFT: begin
                    sr  <= sr_sh;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        bcd_q <= bcd_nx;
                        ovf_q <= ovf_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_seq_bin2bcd.sv
// Bench for seq_bin2bcd: a 3-digit and a 2-digit converter run in lockstep
// from the same stimulus; results are compared to an arithmetic model.
module tb_seq_bin2bcd;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [BW-1:0] binary = '0;
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;

    seq_bin2bcd_if #(.BIN_W(BW), .DIGITS(3)) i3 ();
    seq_bin2bcd_if #(.BIN_W(BW), .DIGITS(2)) i2 ();
    assign i3.start = start;  assign i3.binary = binary;
    assign i2.start = start;  assign i2.binary = binary;

    seq_bin2bcd #(.BIN_W(BW), .DIGITS(3)) u3 (.clk(clk), .rst(rst), .bus(i3));
    seq_bin2bcd #(.BIN_W(BW), .DIGITS(2)) u2 (.clk(clk), .rst(rst), .bus(i2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned v;
        logic [11:0] e3;
        logic        o3;
        logic [7:0]  e2;
        logic        o2;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Decimal digits by division; saturate to all 9s at >= 10^d
    function automatic logic [15:0] model(input int unsigned v, input int d, output logic ovf);
        logic [15:0] r;
        int unsigned lim, p;
        r = '0; lim = 1;
        for (int k = 0; k < d; k++) lim *= 10;
        ovf = (v >= lim);
        p = 1;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = ovf ? 4'd9 : 4'((v / p) % 10);
            p *= 10;
        end
`ifdef BIN2BCD_BLANK_LEADING_EN
        if (!ovf) begin
            p = 1;
            for (int k = 1; k < d; k++) begin
                p *= 10;
                if (v < p) r[4*k +: 4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!i3.ready && n < 40) begin @(posedge clk); #1; n++; end
        chk("ready_wait", 32'(i3.ready), 1);
    endtask

    task automatic conv(input int unsigned v, output logic [11:0] b3, output logic o3,
                        output logic [7:0] b2, output logic o2);
        int n;
        bit hit;
        wait_ready();
        binary = BW'(v); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; binary = BW'($urandom);
        n = 0; hit = 1'b0;
        while (!hit && n < 30) begin @(posedge clk); #1; n++; hit = i3.done; end
        chk("latency", n, BW + 1);
        chk("done_d2", 32'(i2.done), 1);
        b3 = i3.bcd; o3 = i3.overflow; b2 = i2.bcd; o2 = i2.overflow;
        @(posedge clk); #1;
        chk("done_pulse", 32'(i3.done), 0);
        chk("ready_after", 32'(i3.ready), 1);
    endtask

    initial begin
        vec_t        tbl[9];
        logic [11:0] b3, e3;
        logic [7:0]  b2;
        logic [15:0] m;
        logic        o3, o2, eo;
        int          n, cnt, last_d;
        bit          hit;
        int unsigned v, vals[3];

`ifdef BIN2BCD_BLANK_LEADING_EN
        tbl = '{'{0, 12'hFF0, 0, 8'hF0, 0}, '{9, 12'hFF9, 0, 8'hF9, 0},
                '{100, 12'h100, 0, 8'h99, 1}, '{255, 12'h255, 0, 8'h99, 1},
                '{123, 12'h123, 0, 8'h99, 1}, '{99, 12'hF99, 0, 8'h99, 0},
                '{7, 12'hFF7, 0, 8'hF7, 0}, '{105, 12'h105, 0, 8'h99, 1},
                '{10, 12'hF10, 0, 8'h10, 0}};
`else
        tbl = '{'{0, 12'h000, 0, 8'h00, 0}, '{9, 12'h009, 0, 8'h09, 0},
                '{100, 12'h100, 0, 8'h99, 1}, '{255, 12'h255, 0, 8'h99, 1},
                '{123, 12'h123, 0, 8'h99, 1}, '{99, 12'h099, 0, 8'h99, 0},
                '{7, 12'h007, 0, 8'h07, 0}, '{105, 12'h105, 0, 8'h99, 1},
                '{10, 12'h010, 0, 8'h10, 0}};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(i3.ready), 1);
        chk("rst_done", 32'(i3.done), 0);
        chk("rst_bcd", 32'(i3.bcd), 0);
        chk("rst_ovf", 32'(i3.overflow), 0);
        chk("rst_ready2", 32'(i2.ready), 1);
        chk("rst_bcd2", 32'(i2.bcd), 0);
        rst = 1'b0;

        // Table vectors
        for (int i = 0; i < 9; i++) begin
            conv(tbl[i].v, b3, o3, b2, o2);
            chk($sformatf("tbl_bcd3[%0d]", tbl[i].v), 32'(b3), 32'(tbl[i].e3));
            chk($sformatf("tbl_ovf3[%0d]", tbl[i].v), 32'(o3), 32'(tbl[i].o3));
            chk($sformatf("tbl_bcd2[%0d]", tbl[i].v), 32'(b2), 32'(tbl[i].e2));
            chk($sformatf("tbl_ovf2[%0d]", tbl[i].v), 32'(o2), 32'(tbl[i].o2));
        end

        // Start held high: three back-to-back conversions
        wait_ready();
        vals = '{0, 9, 100};
        start = 1'b1;
        last_d = 0;
        for (int i = 0; i < 3; i++) begin
            binary = BW'(vals[i]);
            n = 0; hit = 1'b0;
            while (!hit && n < 30) begin @(posedge clk); #1; n++; hit = i3.done; end
            chk("b2b_done", 32'(hit), 1);
            m = model(vals[i], 3, eo);
            chk("b2b_bcd", 32'(i3.bcd), 32'(m[11:0]));
            if (i > 0) chk("b2b_spacing", cyc - last_d, BW + 2);
            last_d = cyc;
        end
        start = 1'b0;

        // Second start during SHIFT is ignored
        wait_ready();
        binary = 8'd200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        binary = 8'd50; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; binary = '0;
        cnt = 0; b3 = '0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (i3.done) begin cnt++; b3 = i3.bcd; end
        end
        chk("ign_pulses", cnt, 1);
        m = model(200, 3, eo);
        chk("ign_bcd", 32'(b3), 32'(m[11:0]));

        // Reset in the middle of a conversion
        wait_ready();
        binary = 8'd200; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_ready", 32'(i3.ready), 1);
        chk("abort_done", 32'(i3.done), 0);
        chk("abort_bcd", 32'(i3.bcd), 0);
        chk("abort_ovf2", 32'(i2.overflow), 0);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i3.done) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        conv(37, b3, o3, b2, o2);
        m = model(37, 3, eo);
        chk("after_abort_bcd", 32'(b3), 32'(m[11:0]));
        chk("after_abort_ovf", 32'(o3), 32'(eo));

        // Random values against the model
        for (int i = 0; i < 40; i++) begin
            v = $urandom_range(0, 255);
            conv(v, b3, o3, b2, o2);
            m = model(v, 3, eo);
            e3 = m[11:0];
            chk($sformatf("rnd_bcd3[%0d]", v), 32'(b3), 32'(e3));
            chk($sformatf("rnd_ovf3[%0d]", v), 32'(o3), 32'(eo));
            m = model(v, 2, eo);
            chk($sformatf("rnd_bcd2[%0d]", v), 32'(b2), 32'(m[7:0]));
            chk($sformatf("rnd_ovf2[%0d]", v), 32'(o2), 32'(eo));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
